// File: rtl/prod_accumulator.sv
// Dot-product accumulator: sums N_TERMS signed products from the shift-add multiplier
// into a saturating AW-bit sum, then presents it with a one-cycle valid pulse.
module prod_accumulator #(
    parameter int PW      = 16,
    parameter int AW      = 24,
    parameter int N_TERMS = 8,
    parameter int CW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [PW-1:0] prd_in,
    input  logic          prd_en,
    output logic [AW-1:0] acc_out,
    output logic          acc_vld,
    output logic          busy,
    output logic          ovf,
    output logic [CW-1:0] term_cnt
);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        ACC  = 3'b010,
        DONE = 3'b100
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [AW-1:0] acc_out_q, acc_out_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    logic [AW-1:0] prd_ext;
    logic [AW-1:0] sum_raw;
    logic [AW-1:0] sum_sat;
    logic          add_ovf;

    // Overflow only when both operands share a sign and the result's sign differs;
    // the clamp direction follows the product's sign.
    assign prd_ext = AW'($signed(prd_in));
    assign sum_raw = acc_q + prd_ext;
    assign add_ovf = (acc_q[AW-1] == prd_ext[AW-1]) && (sum_raw[AW-1] != acc_q[AW-1]);
    assign sum_sat = !add_ovf    ? sum_raw :
                     prd_ext[AW-1] ? {1'b1, {(AW-1){1'b0}}} :
                                     {1'b0, {(AW-1){1'b1}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            acc_out_q <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            acc_out_q <= acc_out_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        acc_out_d = acc_out_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACC;
                end
            end
            ACC: begin
                // start outranks a coincident strobe: that product is dropped
                if (start) begin
                    acc_d = '0;
                    cnt_d = '0;
                    ovf_d = 1'b0;
                end else if (prd_en) begin
                    acc_d = sum_sat;
                    cnt_d = cnt_q + CW'(1);
                    ovf_d = ovf_q | add_ovf;
                    if (cnt_q == CW'(N_TERMS - 1)) begin
                        acc_out_d = sum_sat;
                        state_d   = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign acc_out  = acc_out_q;
    assign acc_vld  = (state_q == DONE);
    assign busy     = (state_q == ACC);
    assign ovf      = ovf_q;
    assign term_cnt = cnt_q;

endmodule

// File: tb/tb_prod_accumulator.sv
// Directed bench for prod_accumulator: a default-width instance plus an AW=18
// instance sharing the same stimulus so saturation can be reached with 8 terms.
module tb_prod_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] prdIn = '0;
    logic        prdEn = 1'b0;

    logic [23:0] accOut;
    logic        accVld, busy, ovf;
    logic [3:0]  termCnt;

    logic [17:0] accOutS;
    logic        accVldS, busyS, ovfS;
    logic [3:0]  termCntS;

    int vecCount  = 0;
    int missCount = 0;

    always #5 clk = ~clk;

    prod_accumulator dut (
        .clk(clk), .rst(rst), .start(start), .prd_in(prdIn), .prd_en(prdEn),
        .acc_out(accOut), .acc_vld(accVld), .busy(busy), .ovf(ovf), .term_cnt(termCnt)
    );

    prod_accumulator #(.AW(18)) dutSat (
        .clk(clk), .rst(rst), .start(start), .prd_in(prdIn), .prd_en(prdEn),
        .acc_out(accOutS), .acc_vld(accVldS), .busy(busyS), .ovf(ovfS), .term_cnt(termCntS)
    );

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic applyStrobe(input logic [15:0] value);
        prdIn = value;
        prdEn = 1'b1;
        tick();
        prdEn = 1'b0;
    endtask

    task automatic test_reset_state();
        vecCount++;
        if ({accOut, accVld, busy, ovf, termCnt} !== 31'd0) begin
            missCount++;
            $display("[TB] FAIL reset_state: got out=%h vld=%b busy=%b ovf=%b cnt=%0d expected all zero",
                     accOut, accVld, busy, ovf, termCnt);
        end
    endtask

    task automatic test_basic();
        applyStart();
        for (int i = 0; i < 8; i++) begin
            applyStrobe(16'd15);
            if (i < 7) begin
                vecCount++;
                if (accVld !== 1'b0 || busy !== 1'b1) begin
                    missCount++;
                    $display("[TB] FAIL basic_midrun[%0d]: got vld=%b busy=%b expected vld=0 busy=1", i, accVld, busy);
                end
                repeat (9) tick();
            end
        end
        vecCount++;
        if (accVld !== 1'b1 || accOut !== 24'd120 || ovf !== 1'b0 || termCnt !== 4'd8) begin
            missCount++;
            $display("[TB] FAIL basic_done: got vld=%b out=%0d ovf=%b cnt=%0d expected vld=1 out=120 ovf=0 cnt=8",
                     accVld, accOut, ovf, termCnt);
        end
        tick();
        vecCount++;
        if (accVld !== 1'b0 || busy !== 1'b0 || accOut !== 24'd120 || termCnt !== 4'd8) begin
            missCount++;
            $display("[TB] FAIL basic_hold: got vld=%b busy=%b out=%0d cnt=%0d expected vld=0 busy=0 out=120 cnt=8",
                     accVld, busy, accOut, termCnt);
        end
    endtask

    task automatic test_reset_midrun();
        logic sawVld;
        applyStart();
        for (int i = 0; i < 3; i++) applyStrobe(16'd7);
        vecCount++;
        if (termCnt !== 4'd3 || busy !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL reset_precond: got cnt=%0d busy=%b expected cnt=3 busy=1", termCnt, busy);
        end
        #2 rst = 1'b1;
        #1;
        vecCount++;
        if ({accOut, accVld, busy, ovf, termCnt} !== 31'd0) begin
            missCount++;
            $display("[TB] FAIL reset_midrun: got out=%h vld=%b busy=%b ovf=%b cnt=%0d expected all zero",
                     accOut, accVld, busy, ovf, termCnt);
        end
        sawVld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            sawVld |= accVld;
        end
        rst = 1'b0;
        tick();
        sawVld |= accVld | busy;
        vecCount++;
        if (sawVld !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL reset_novld: got vld_or_busy=%b expected 0", sawVld);
        end
    endtask

    task automatic test_signed();
        logic [15:0] vals [8] = '{16'd100, -16'sd50, -16'sd16384, 16'd16384, 16'd7, -16'sd7, 16'd1, -16'sd1};
        applyStart();
        for (int i = 0; i < 8; i++) applyStrobe(vals[i]);
        vecCount++;
        if (accVld !== 1'b1 || accOut !== 24'd50 || accOutS !== 18'd50 || ovf !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL signed_mix: got vld=%b out=%0d outS=%0d ovf=%b expected vld=1 out=50 outS=50 ovf=0",
                     accVld, accOut, accOutS, ovf);
        end
        tick();
        applyStart();
        for (int i = 0; i < 8; i++) applyStrobe(16'hC000);
        vecCount++;
        if (accOut !== 24'hFE0000 || accOutS !== 18'h20000 || ovf !== 1'b0 || ovfS !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL signed_neg: got out=%h outS=%h ovf=%b ovfS=%b expected out=fe0000 outS=20000 ovf=0 ovfS=0",
                     accOut, accOutS, ovf, ovfS);
        end
        tick();
    endtask

    task automatic test_saturate();
        applyStart();
        for (int i = 0; i < 8; i++) applyStrobe(16'h7FFF);
        vecCount++;
        if (accOutS !== 18'h1FFFF || ovfS !== 1'b1 || accOut !== 24'h03FFF8 || ovf !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL sat_pos: got outS=%h ovfS=%b out=%h ovf=%b expected outS=1ffff ovfS=1 out=03fff8 ovf=0",
                     accOutS, ovfS, accOut, ovf);
        end
        tick();
        vecCount++;
        if (ovfS !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL sat_sticky: got ovfS=%b expected 1", ovfS);
        end
        applyStart();
        vecCount++;
        if (ovfS !== 1'b0 || accOutS !== 18'h1FFFF || busyS !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL sat_clear: got ovfS=%b outS=%h busyS=%b expected ovfS=0 outS=1ffff busyS=1",
                     ovfS, accOutS, busyS);
        end
        for (int i = 0; i < 8; i++) applyStrobe(16'h8000);
        vecCount++;
        if (accOutS !== 18'h20000 || ovfS !== 1'b1 || accOut !== 24'hFC0000 || ovf !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL sat_neg: got outS=%h ovfS=%b out=%h ovf=%b expected outS=20000 ovfS=1 out=fc0000 ovf=0",
                     accOutS, ovfS, accOut, ovf);
        end
        tick();
    endtask

    task automatic test_restart();
        applyStart();
        for (int i = 0; i < 3; i++) applyStrobe(16'd10);
        start = 1'b1;
        applyStrobe(16'd99);
        start = 1'b0;
        vecCount++;
        if (termCnt !== 4'd0 || busy !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL restart_clear: got cnt=%0d busy=%b expected cnt=0 busy=1", termCnt, busy);
        end
        for (int i = 0; i < 8; i++) applyStrobe(16'd1);
        vecCount++;
        if (accVld !== 1'b1 || accOut !== 24'd8 || termCnt !== 4'd8) begin
            missCount++;
            $display("[TB] FAIL restart_sum: got vld=%b out=%0d cnt=%0d expected vld=1 out=8 cnt=8", accVld, accOut, termCnt);
        end
    endtask

    // Entered with the DUT in DONE after a sum of 8.
    task automatic test_ignore();
        applyStrobe(16'd5);
        vecCount++;
        if (termCnt !== 4'd8 || accOut !== 24'd8 || accVld !== 1'b0 || busy !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL ignore_done: got cnt=%0d out=%0d vld=%b busy=%b expected cnt=8 out=8 vld=0 busy=0",
                     termCnt, accOut, accVld, busy);
        end
        for (int i = 0; i < 3; i++) applyStrobe(16'd33);
        vecCount++;
        if (termCnt !== 4'd8 || accOut !== 24'd8 || busy !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL ignore_idle: got cnt=%0d out=%0d busy=%b expected cnt=8 out=8 busy=0", termCnt, accOut, busy);
        end
        applyStart();
        for (int i = 0; i < 8; i++) applyStrobe(16'd2);
        vecCount++;
        if (accVld !== 1'b1 || accOut !== 24'd16) begin
            missCount++;
            $display("[TB] FAIL ignore_run: got vld=%b out=%0d expected vld=1 out=16", accVld, accOut);
        end
        applyStart();
        vecCount++;
        if (busy !== 1'b1 || termCnt !== 4'd0 || accVld !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL start_in_done: got busy=%b cnt=%0d vld=%b expected busy=1 cnt=0 vld=0", busy, termCnt, accVld);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        test_reset_state();
        rst = 1'b0;
        tick();
        test_basic();
        test_reset_midrun();
        test_signed();
        test_saturate();
        test_restart();
        test_ignore();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
